mem_arbiter: RTL and testbench

Two-port arbiter that shares one single-port synchronous word memory between the instruction-fetch requester and the load/store requester of the multicycle core. Fetch accesses are read-only; the data port supports byte-enabled writes. Selection is round-robin, with one outstanding access at a time, and every access completes with a one-cycle completion pulse. The block sits between the core's sequencer and the memory macro, replacing the core's direct fetch-address hookup.

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between a
// read-only fetch port and a byte-enabled load/store port, one access in flight.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_en,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata
);

  typedef enum logic {StIdle, StResp} state_e;
  typedef enum logic {PortI, PortD} port_e;

  state_e r_state, w_state_d;
  port_e  r_owner, w_owner_d;
  port_e  r_last, w_last_d;
  logic   r_owner_we, w_owner_we_d;
  logic   w_gnt_i, w_gnt_d;

  // On a tie the port that was not granted last time wins.
  always_comb begin
    w_gnt_i = 1'b0;
    w_gnt_d = 1'b0;
    if (!rst && r_state == StIdle) begin
      if (i_req && (!d_req || r_last == PortD)) begin
        w_gnt_i = 1'b1;
      end else if (d_req) begin
        w_gnt_d = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_owner_d    = r_owner;
    w_last_d     = r_last;
    w_owner_we_d = r_owner_we;
    i_gnt        = w_gnt_i;
    d_gnt        = w_gnt_d;
    i_rvalid     = 1'b0;
    i_rdata      = '0;
    d_rvalid     = 1'b0;
    d_rdata      = '0;
    m_en         = 1'b0;
    m_we         = 1'b0;
    m_be         = '0;
    m_addr       = '0;
    m_wdata      = '0;
    unique case (r_state)
      StIdle: begin
        if (w_gnt_i) begin
          m_en         = 1'b1;
          m_addr       = i_addr;
          m_be         = '1;
          w_state_d    = StResp;
          w_owner_d    = PortI;
          w_owner_we_d = 1'b0;
          w_last_d     = PortI;
        end else if (w_gnt_d) begin
          m_en         = 1'b1;
          m_we         = d_we;
          m_addr       = d_addr;
          m_be         = d_we ? d_be : '1;
          m_wdata      = d_wdata;
          w_state_d    = StResp;
          w_owner_d    = PortD;
          w_owner_we_d = d_we;
          w_last_d     = PortD;
        end
      end
      StResp: begin
        w_state_d = StIdle;
        if (!rst) begin
          if (r_owner == PortI) begin
            i_rvalid = 1'b1;
            i_rdata  = r_owner_we ? '0 : m_rdata;
          end else begin
            d_rvalid = 1'b1;
            d_rdata  = r_owner_we ? '0 : m_rdata;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // last resets to D so the first tie after reset goes to fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_owner    <= PortI;
      r_last     <= PortD;
      r_owner_we <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_owner    <= w_owner_d;
      r_last     <= w_last_d;
      r_owner_we <= w_owner_we_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: transaction-level model predicts grants and
// queues expected completions; a negedge monitor compares against the DUT.
module tb_mem_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [BW-1:0] d_be = '0;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid, m_en, m_we;
  logic [DW-1:0] i_rdata, d_rdata, m_wdata, m_rdata;
  logic [BW-1:0] m_be;
  logic [AW-1:0] m_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Memory macro model; loaded once from init_mem.
  logic [DW-1:0] init_mem [0:(1<<AW)-1];
  logic [DW-1:0] mem      [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem  [0:(1<<AW)-1];
  logic          load = 1'b1;

  always @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < (1 << AW); k++) mem[k] <= init_mem[k];
    end else if (m_en) begin
      m_rdata <= mem[m_addr];
      if (m_we) mem[m_addr] <= merge(mem[m_addr], m_wdata, m_be);
    end
  end

  typedef struct packed {logic port; logic [DW-1:0] data;} exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state: port 0 = fetch, 1 = data.
  bit            armed = 1'b0;
  bit            md_busy = 1'b0, md_pend = 1'b0, md_last = 1'b1;
  bit            e_ign, e_dgn, e_irv, e_drv, e_we, e_rst;
  logic [AW-1:0] e_addr;
  logic [BW-1:0] e_be;
  logic [DW-1:0] e_wd;
  logic [DW-1:0] last_ird = '0, last_drd = '0;

  task automatic step(input bit r, input bit ir, input logic [AW-1:0] ia, input bit dr,
                      input bit dw, input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                      input logic [BW-1:0] dbe);
    @(posedge clk);
    #1;
    rst = r; i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da;
    d_wdata = dwd; d_be = dbe;
    e_ign = 0; e_dgn = 0; e_irv = 0; e_drv = 0; e_we = 0; e_rst = r;
    e_addr = '0; e_be = '0; e_wd = '0;
    if (r) begin
      md_busy = 0; md_last = 1; exp_q.delete();
    end else if (md_busy) begin
      if (md_pend) e_drv = 1; else e_irv = 1;
      md_busy = 0;
    end else if (ir && (!dr || md_last)) begin
      e_ign = 1; e_addr = ia; e_be = '1;
      exp_q.push_back('{port: 1'b0, data: ref_mem[ia]});
      md_busy = 1; md_pend = 0; md_last = 0;
    end else if (dr) begin
      e_dgn = 1; e_addr = da; e_we = dw; e_be = dw ? dbe : '1; e_wd = dwd;
      exp_q.push_back('{port: 1'b1, data: dw ? '0 : ref_mem[da]});
      if (dw) ref_mem[da] = merge(ref_mem[da], dwd, dbe);
      md_busy = 1; md_pend = 1; md_last = 1;
    end
    armed = 1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, '0, 0, 0, '0, '0, '0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      chk("i_gnt", i_gnt, e_ign);
      chk("d_gnt", d_gnt, e_dgn);
      chk("m_en", m_en, e_ign | e_dgn);
      chk("i_rvalid", i_rvalid, e_irv);
      chk("d_rvalid", d_rvalid, e_drv);
      if (e_ign || e_dgn || e_rst) begin
        chk("m_addr", m_addr, e_addr);
        chk("m_we", m_we, e_we);
        chk("m_be", m_be, e_be);
        chk("m_wdata", m_wdata, e_wd);
      end
      if (i_rvalid) begin
        if (exp_q.size() == 0) chk("i_rvalid_no_pending", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("i_owner", 0, e.port);
          chk("i_rdata", i_rdata, e.data);
          last_ird = i_rdata;
        end
      end else chk("i_rdata_idle", i_rdata, 0);
      if (d_rvalid) begin
        if (exp_q.size() == 0) chk("d_rvalid_no_pending", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("d_owner", 1, e.port);
          chk("d_rdata", d_rdata, e.data);
          last_drd = d_rdata;
        end
      end else chk("d_rdata_idle", d_rdata, 0);
    end
  end

  initial begin
    for (int k = 0; k < (1 << AW); k++) init_mem[k] = $urandom;
    init_mem[5] = 32'hDEADBEEF;
    init_mem[3] = 32'h0;
    for (int k = 0; k < (1 << AW); k++) ref_mem[k] = init_mem[k];

    // Reset held with both ports requesting, then fetch wins the first tie.
    for (int k = 0; k < 3; k++) step(1, 1, 7'd1, 1, 0, 7'd2, '0, '0);
    load = 1'b0;
    step(0, 1, 7'd9, 1, 0, 7'd2, '0, '0);
    idle(2);

    // Single fetch of word 5.
    step(0, 1, 7'd5, 0, 0, '0, '0, '0);
    idle(2);
    chk("fetch_word5", last_ird, 32'hDEADBEEF);

    // Byte-enabled write then read back.
    step(0, 0, '0, 1, 1, 7'd3, 32'h11223344, 4'b0101);
    idle(1);
    step(0, 0, '0, 1, 0, 7'd3, '0, '0);
    idle(2);
    chk("byte_write_read", last_drd, 32'h00220044);

    // Both ports held: grants must alternate.
    for (int k = 0; k < 8; k++) step(0, 1, 7'd5, 1, 0, 7'd3, '0, '0);
    idle(2);

    // Data request pulsed only during a fetch's RESP, fetch held through RESP.
    step(0, 1, 7'd5, 0, 0, '0, '0, '0);
    step(0, 1, 7'd5, 1, 1, 7'd7, 32'hFFFFFFFF, 4'hF);
    step(0, 1, 7'd5, 0, 0, '0, '0, '0);
    idle(2);
    step(0, 0, '0, 1, 0, 7'd7, '0, '0);
    idle(2);

    // Write with no byte enables still completes.
    step(0, 0, '0, 1, 1, 7'd6, 32'hA5A5A5A5, 4'b0000);
    idle(2);

    // Reset in the RESP cycle of a data read; next tie goes to fetch.
    step(0, 0, '0, 1, 0, 7'd3, '0, '0);
    step(1, 1, 7'd5, 1, 0, 7'd3, '0, '0);
    step(0, 1, 7'd5, 1, 0, 7'd3, '0, '0);
    idle(3);

    // Randomized traffic on a small address window so reads hit earlier writes.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 64) == 0, 1'($urandom % 2), 7'($urandom_range(0, 7)),
           1'($urandom % 2), 1'($urandom % 2), 7'($urandom_range(0, 7)),
           32'($urandom), 4'($urandom % 16));
    end
    idle(3);
    chk("queue_drained", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
